gloves_pos_ctrl: RTL and testbench

Frame-synchronous controller for the gloves sprite path.
- Samples the mouse position once per frame during vertical blank.
- Clamps it to the screen, rate-limits motion, and publishes a stable sprite origin for the whole next frame.
- During each horizontal blank, pre-computes the sprite ROM row base address for the upcoming line with a sequential shift-add multiplier, so the pixel path needs only one add per pixel.
- Sits between the mouse/game-state logic and the gloves drawing stage.

---
 rtl/draw_pkg.sv | 40 ++++
 rtl/gloves_pos_ctrl_if.sv | 29 ++
 rtl/const_mult_seq.sv | 51 +++++
 rtl/gloves_pos_ctrl.sv | 151 +++++++++++++++
 tb/tb_gloves_pos_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared constants, state encodings and helpers for the sprite drawing path.
package draw_pkg;

    localparam int GLOVES_LENGTH = 100;
    localparam int SCREEN_X_MAX  = 1024;
    localparam int SCREEN_Y_MAX  = 768;

    typedef enum logic [2:0] {
        WAIT_VB,
        SAMPLE,
        STEP,
        PUBLISH,
        WAIT_ACT
    } frame_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_MUL,
        R_DONE
    } row_state_t;

    function automatic logic [11:0] clamp12(
        input logic [11:0] v,
        input logic [11:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

    // Move cur toward tgt by at most step, never wrapping below zero.
    function automatic logic [11:0] step_axis(
        input logic [11:0] cur,
        input logic [11:0] tgt,
        input logic [11:0] step
    );
        if (tgt >= cur)
            return (tgt - cur <= step) ? tgt : cur + step;
        return (cur - tgt <= step) ? tgt : cur - step;
    endfunction

endpackage

// File: rtl/gloves_pos_ctrl_if.sv
// Timing, mouse and game-state inputs plus sprite origin / row outputs.
interface gloves_pos_ctrl_if;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        vblnk;
    logic        hblnk;
    logic [10:0] vcount;
    logic        enable;
    logic        freeze;
    logic [11:0] x_ow;
    logic [9:0]  y_ow;
    logic        visible;
    logic        frame_tick;
    logic [19:0] row_base;
    logic        row_hit;
    logic        row_ready;

    modport master (
        output xpos, ypos, vblnk, hblnk, vcount, enable, freeze,
        input  x_ow, y_ow, visible, frame_tick,
        input  row_base, row_hit, row_ready
    );

    modport slave (
        input  xpos, ypos, vblnk, hblnk, vcount, enable, freeze,
        output x_ow, y_ow, visible, frame_tick,
        output row_base, row_hit, row_ready
    );
endinterface

// File: rtl/const_mult_seq.sv
// Sequential shift-add multiply by a constant, one multiplier bit per
// clock, LSB first; done pulses after the last bit.
module const_mult_seq #(
    parameter int K  = 100,
    parameter int AW = 7,
    parameter int PW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] a,
    output logic          done,
    output logic [PW-1:0] p
);
    localparam int CW = $clog2(AW + 1);

    logic [PW-1:0] mc;
    logic [AW-1:0] mp;
    logic [CW-1:0] cnt;
    logic          busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            p    <= '0;
            mc   <= '0;
            mp   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                p    <= '0;
                mc   <= PW'(K);
                mp   <= a;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (mp[0])
                    p <= p + mc;
                mc  <= mc << 1;
                mp  <= mp >> 1;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(AW - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/gloves_pos_ctrl.sv
// Frame-synchronous gloves sprite origin controller with a per-line
// ROM row base pre-computation engine.
module gloves_pos_ctrl
    import draw_pkg::*;
#(
    parameter int X_MAX    = SCREEN_X_MAX,
    parameter int Y_MAX    = SCREEN_Y_MAX,
    parameter int MAX_STEP = 32,
    parameter int OFFSET   = 50,
    parameter int IMG_W    = GLOVES_LENGTH,
    parameter int V_TOTAL  = 806
) (
    input logic             clk,
    input logic             rst,
    gloves_pos_ctrl_if.slave bus
);
    frame_state_t fst;
    row_state_t   rst_q;

    logic        vb_d, vb_rise, hb_d;
    logic [11:0] tgt_x, tgt_y, cur_x, cur_y;
    logic [11:0] x_ow;
    logic [9:0]  y_ow;
    logic        visible, frame_tick;
    logic [19:0] row_base;
    logic        row_hit, row_ready;

    logic [10:0] nl;
    logic [11:0] ny, y_top, y_end;
    logic        hit_c, hit_q;
    logic [6:0]  r_c, r_q;
    logic        mul_start, mul_done;
    logic [19:0] mul_p;

    // vb_d/hb_d come out of reset high so a blank in progress is not
    // mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fst        <= WAIT_VB;
            vb_d       <= 1'b1;
            vb_rise    <= 1'b0;
            tgt_x      <= '0;
            tgt_y      <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            x_ow       <= '0;
            y_ow       <= '0;
            visible    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vb_d       <= bus.vblnk;
            vb_rise    <= bus.vblnk & ~vb_d;
            frame_tick <= 1'b0;
            unique case (fst)
                WAIT_VB:
                    if (vb_rise) fst <= SAMPLE;
                SAMPLE: begin
                    if (!bus.freeze) begin
                        tgt_x <= clamp12(bus.xpos, 12'(X_MAX));
                        tgt_y <= clamp12(bus.ypos, 12'(Y_MAX));
                    end
                    fst <= STEP;
                end
                STEP: begin
                    cur_x <= step_axis(cur_x, tgt_x, 12'(MAX_STEP));
                    cur_y <= step_axis(cur_y, tgt_y, 12'(MAX_STEP));
                    fst   <= PUBLISH;
                end
                PUBLISH: begin
                    x_ow       <= cur_x;
                    y_ow       <= cur_y[9:0];
                    visible    <= bus.enable;
                    frame_tick <= 1'b1;
                    fst        <= WAIT_ACT;
                end
                WAIT_ACT:
                    if (!bus.vblnk) fst <= WAIT_VB;
                default:
                    fst <= WAIT_VB;
            endcase
        end
    end

    assign nl = (bus.vcount == 11'(V_TOTAL - 1)) ? 11'd0
              : bus.vcount + 11'd1;
    assign ny    = {1'b0, nl} + 12'(OFFSET);
    assign y_top = {2'b0, y_ow};
    assign y_end = y_top + 12'(IMG_W);
    assign hit_c = visible && (ny >= y_top) && (ny < y_end);
    assign r_c   = 7'(ny - y_top);

    // A fresh hblnk edge always wins, restarting any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q     <= R_IDLE;
            hb_d      <= 1'b1;
            hit_q     <= 1'b0;
            r_q       <= '0;
            mul_start <= 1'b0;
            row_base  <= '0;
            row_hit   <= 1'b0;
            row_ready <= 1'b0;
        end else begin
            hb_d      <= bus.hblnk;
            mul_start <= 1'b0;
            row_ready <= 1'b0;
            if (bus.hblnk && !hb_d) begin
                hit_q     <= hit_c;
                r_q       <= r_c;
                mul_start <= 1'b1;
                rst_q     <= R_MUL;
            end else begin
                unique case (rst_q)
                    R_IDLE: ;
                    R_MUL:
                        if (mul_done) begin
                            row_base  <= hit_q ? mul_p : 20'd0;
                            row_hit   <= hit_q;
                            row_ready <= 1'b1;
                            rst_q     <= R_DONE;
                        end
                    R_DONE:
                        rst_q <= R_IDLE;
                    default:
                        rst_q <= R_IDLE;
                endcase
            end
        end
    end

    const_mult_seq #(
        .K  (IMG_W),
        .AW (7),
        .PW (20)
    ) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (r_q),
        .done  (mul_done),
        .p     (mul_p)
    );

    assign bus.x_ow       = x_ow;
    assign bus.y_ow       = y_ow;
    assign bus.visible    = visible;
    assign bus.frame_tick = frame_tick;
    assign bus.row_base   = row_base;
    assign bus.row_hit    = row_hit;
    assign bus.row_ready  = row_ready;
endmodule

// File: tb/tb_gloves_pos_ctrl.sv
// Randomized bench for gloves_pos_ctrl against an arithmetic frame/row model.
module tb_gloves_pos_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gloves_pos_ctrl_if bus();

    gloves_pos_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    int m_tx = 0, m_ty = 0, m_cx = 0, m_cy = 0;
    int m_xo = 0, m_yo = 0, m_vis = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mv(input int c, input int t);
        if (t - c > 32) return c + 32;
        if (c - t > 32) return c - 32;
        return t;
    endfunction

    task automatic model_reset();
        m_tx = 0; m_ty = 0; m_cx = 0; m_cy = 0;
        m_xo = 0; m_yo = 0; m_vis = 0;
    endtask

    task automatic frame(input int x, input int y,
                         input int en, input int frz);
        int ticks;
        int lat;
        @(negedge clk);
        bus.xpos   = 12'(x);
        bus.ypos   = 12'(y);
        bus.enable = en[0];
        bus.freeze = frz[0];
        bus.vblnk  = 1'b1;
        ticks = 0;
        lat   = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.frame_tick) begin
                ticks++;
                if (lat < 0) lat = k - 1;
            end
        end
        bus.vblnk = 1'b0;
        repeat (3) @(negedge clk);
        if (frz == 0) begin
            m_tx = (x > 1024) ? 1024 : x;
            m_ty = (y > 768) ? 768 : y;
        end
        m_cx  = mv(m_cx, m_tx);
        m_cy  = mv(m_cy, m_ty);
        m_xo  = m_cx;
        m_yo  = m_cy % 1024;
        m_vis = en;
        chk("tick_count", ticks, 1);
        chk("tick_lat", lat, 4);
        chk("x_ow", 32'(bus.x_ow), m_xo);
        chk("y_ow", 32'(bus.y_ow), m_yo);
        chk("visible", 32'(bus.visible), m_vis);
    endtask

    task automatic row(input int vc);
        int lat;
        int rdy;
        int nl;
        int s;
        int hit;
        int base;
        logic [19:0] got_base;
        logic        got_hit;
        @(negedge clk);
        bus.vcount = 11'(vc);
        bus.hblnk  = 1'b1;
        lat = -1;
        rdy = 0;
        got_base = '0;
        got_hit  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.row_ready) begin
                rdy++;
                if (lat < 0) begin
                    lat      = k - 1;
                    got_base = bus.row_base;
                    got_hit  = bus.row_hit;
                end
            end
        end
        bus.hblnk = 1'b0;
        repeat (2) @(negedge clk);
        nl   = (vc == 805) ? 0 : vc + 1;
        s    = nl + 50;
        hit  = (m_vis != 0 && s >= m_yo && s < m_yo + 100) ? 1 : 0;
        base = (hit != 0) ? (s - m_yo) * 100 : 0;
        chk("row_ready_count", rdy, 1);
        chk("row_lat", lat, 9);
        chk("row_hit", 32'(got_hit), hit);
        chk("row_base", 32'(got_base), base);
    endtask

    initial begin
        int ticks;
        int rdy;
        rst        = 1'b1;
        bus.xpos   = '0;
        bus.ypos   = '0;
        bus.vblnk  = 1'b1;
        bus.hblnk  = 1'b0;
        bus.vcount = '0;
        bus.enable = 1'b1;
        bus.freeze = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_x_ow", 32'(bus.x_ow), 0);
        chk("rst_y_ow", 32'(bus.y_ow), 0);
        chk("rst_visible", 32'(bus.visible), 0);
        chk("rst_row_base", 32'(bus.row_base), 0);
        chk("rst_row_hit", 32'(bus.row_hit), 0);
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        chk("partial_frame_ticks", ticks, 0);
        bus.vblnk = 1'b0;
        repeat (3) @(negedge clk);

        frame(2000, 900, 1, 0);
        chk("step1_x", 32'(bus.x_ow), 32);
        chk("step1_y", 32'(bus.y_ow), 32);
        frame(2000, 900, 1, 0);
        chk("step2_x", 32'(bus.x_ow), 64);

        for (int i = 0; i < 12; i++) frame(300, 200, 1, 0);
        chk("settle_x", 32'(bus.x_ow), 300);
        chk("settle_y", 32'(bus.y_ow), 200);
        for (int i = 0; i < 3; i++) frame(600, 200, 1, 1);
        chk("freeze_x", 32'(bus.x_ow), 300);
        frame(600, 200, 1, 0);
        chk("unfreeze_x", 32'(bus.x_ow), 332);

        for (int i = 0; i < 12; i++) frame(300, 200, 1, 0);
        row(179);
        chk("row179_base", 32'(bus.row_base), 3000);
        row(148);

        for (int i = 0; i < 6; i++) frame(300, 40, 1, 0);
        row(805);
        chk("wrap_base", 32'(bus.row_base), 1000);
        frame(300, 40, 0, 0);
        row(805);
        chk("disabled_hit", 32'(bus.row_hit), 0);

        for (int i = 0; i < 25; i++) frame(1000, 760, 1, 0);
        frame(2000, 900, 1, 0);
        chk("clamp_x", 32'(bus.x_ow), 1024);
        chk("clamp_y", 32'(bus.y_ow), 768);

        for (int i = 0; i < 30; i++) begin
            frame(int'($urandom_range(0, 2047)),
                  int'($urandom_range(0, 1023)),
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  ($urandom_range(0, 4) == 0) ? 1 : 0);
            row(int'($urandom_range(0, 805)));
            row((m_yo >= 51) ? m_yo - 51 + int'($urandom_range(0, 99))
                             : int'($urandom_range(0, 805)));
        end

        for (int i = 0; i < 12; i++) frame(300, 200, 1, 0);
        row(179);
        @(negedge clk);
        bus.vcount = 11'd179;
        bus.hblnk  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midmul_row_base", 32'(bus.row_base), 0);
        chk("midmul_row_hit", 32'(bus.row_hit), 0);
        chk("midmul_x_ow", 32'(bus.x_ow), 0);
        rdy = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.row_ready) rdy++;
        end
        chk("midmul_no_ready", rdy, 0);
        bus.hblnk = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
